// File: rtl/gpio_bus_pkg.sv
// Shared types and frame geometry for the SPI register bridge.
// Frame: 16-bit command (R/nW + 15-bit address), dummy turnaround, 32-bit data.
package gpio_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        TURN,
        DATA,
        WRITE_ISSUE,
        DONE
    } spi_state_e;

    localparam int CMD_BITS   = 16;
    localparam int DATA_BITS  = 32;
    localparam int DUMMY_BITS = 8;
    localparam int FRAME_BITS = CMD_BITS + DUMMY_BITS + DATA_BITS;

    function automatic int frame_bits(input int dummy_bits);
        return CMD_BITS + dummy_bits + DATA_BITS;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Oversampling front end: synchronizes sclk/cs_n/mosi into clklow and
// produces single-cycle edge pulses from the synchronized sclk and cs_n.
module spi_edge_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic cs_n_o,
    output logic mosi_o
);

    logic [SyncStages-1:0] sclk_q, cs_q, mosi_q;
    logic                  sclk_prev_q, cs_prev_q;

    // cs_n resets deasserted so a reset never fabricates a frame start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_q      <= {sclk_q[SyncStages-2:0], sclk_i};
            cs_q        <= {cs_q[SyncStages-2:0], cs_n_i};
            mosi_q      <= {mosi_q[SyncStages-2:0], mosi_i};
            sclk_prev_q <= sclk_q[SyncStages-1];
            cs_prev_q   <= cs_q[SyncStages-1];
        end
    end

    assign sclk_rise_o = sclk_q[SyncStages-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[SyncStages-1] & sclk_prev_q;
    assign cs_fall_o   = ~cs_q[SyncStages-1] & cs_prev_q;
    assign cs_rise_o   = cs_q[SyncStages-1] & ~cs_prev_q;
    assign cs_n_o      = cs_q[SyncStages-1];
    assign mosi_o      = mosi_q[SyncStages-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 56-bit frames into register-bus reads/writes.
// Everything runs in clklow; the SPI pins are oversampled by spi_edge_sync.
import gpio_bus_pkg::*;

module spi_reg_bridge #(
    parameter int AddrWidth  = 16,
    parameter int BusWidth   = 32,
    parameter int SyncStages = 2,
    parameter int DummyBits  = 8,
    parameter int ReadWait   = 6,
    parameter int StrobeLen  = 2
) (
    input  logic                 clklow,
    input  logic                 resetN,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 miso_oe,
    output logic [AddrWidth-1:0] bus_address,
    output logic                 bus_read,
    output logic                 bus_write,
    output logic [BusWidth-1:0]  bus_writedata,
    input  logic [BusWidth-1:0]  bus_readdata,
    output logic                 frame_abort
);

    localparam int CW = $clog2(DATA_BITS) + 1;
    localparam int RW = $clog2(ReadWait + 1) + 1;
    localparam int SW = $clog2(StrobeLen + 1) + 1;

    localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_BITS - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(DummyBits - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [RW-1:0] RD_WAIT   = RW'(ReadWait);
    localparam logic [RW-1:0] RD_STROBE = RW'(StrobeLen);
    localparam logic [SW-1:0] WR_STROBE = SW'(StrobeLen);

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

    spi_edge_sync #(.SyncStages(SyncStages)) u_sync (
        .clk_i       (clklow),
        .rst_ni      (resetN),
        .sclk_i      (spi_sclk),
        .cs_n_i      (spi_cs_n),
        .mosi_i      (spi_mosi),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .cs_n_o      (cs_n_s),
        .mosi_o      (mosi_s)
    );

    spi_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [CMD_BITS-2:0]   cmd_sh_q;
    logic                  rnw_q;
    logic [AddrWidth-1:0]  bus_address_q;
    logic                  bus_read_q, rd_busy_q, rd_keep_q;
    logic [RW-1:0]         rd_cnt_q;
    logic [BusWidth-1:0]   tx_sh_q;
    logic                  miso_q;
    logic [BusWidth-2:0]   rx_sh_q;
    logic [BusWidth-1:0]   bus_writedata_q;
    logic                  bus_write_q;
    logic [SW-1:0]         wr_cnt_q;
    logic                  frame_abort_q;

    logic cmd_done, turn_done, data_done, wr_done, abort, in_frame;

    assign in_frame = (state_q == CMD) || (state_q == TURN) || (state_q == DATA);

    always_comb begin
        state_d   = state_q;
        cmd_done  = 1'b0;
        turn_done = 1'b0;
        data_done = 1'b0;
        wr_done   = 1'b0;
        abort     = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD, TURN, DATA: begin
                if (cs_rise) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    if (state_q == CMD && cnt_q == CMD_LAST) begin
                        cmd_done = 1'b1;
                        state_d  = TURN;
                    end else if (state_q == TURN && cnt_q == TURN_LAST) begin
                        turn_done = 1'b1;
                        state_d   = DATA;
                    end else if (state_q == DATA && cnt_q == DATA_LAST) begin
                        data_done = 1'b1;
                        state_d   = rnw_q ? DONE : WRITE_ISSUE;
                    end
                end
            end
            // A cs_n rise here is deliberately ignored; DONE waits on the level.
            WRITE_ISSUE: if (wr_cnt_q == WR_STROBE) begin
                wr_done = 1'b1;
                state_d = DONE;
            end
            DONE: if (cs_n_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clklow or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clklow or negedge resetN) begin
        if (!resetN) begin
            cnt_q           <= '0;
            cmd_sh_q        <= '0;
            rnw_q           <= 1'b0;
            bus_address_q   <= '0;
            bus_read_q      <= 1'b0;
            rd_busy_q       <= 1'b0;
            rd_keep_q       <= 1'b0;
            rd_cnt_q        <= '0;
            tx_sh_q         <= '0;
            miso_q          <= 1'b0;
            rx_sh_q         <= '0;
            bus_writedata_q <= '0;
            bus_write_q     <= 1'b0;
            wr_cnt_q        <= '0;
            frame_abort_q   <= 1'b0;
        end else begin
            frame_abort_q <= abort;

            if (state_q == IDLE || cmd_done || turn_done || data_done)
                cnt_q <= '0;
            else if (sclk_rise && in_frame)
                cnt_q <= cnt_q + 1'b1;

            if (state_q == CMD && sclk_rise)
                cmd_sh_q <= {cmd_sh_q[CMD_BITS-3:0], mosi_s};

            // cmd_sh_q[13:1] holds addr[14:2] at the 16th rise; addr[1:0] dropped
            if (cmd_done) begin
                rnw_q         <= cmd_sh_q[CMD_BITS-2];
                bus_address_q <= AddrWidth'({cmd_sh_q[CMD_BITS-3:1], 2'b00});
            end

            // Read issue overlaps TURN; an abort lets the strobe finish but drops the data
            if (cmd_done && cmd_sh_q[CMD_BITS-2]) begin
                bus_read_q <= 1'b1;
                rd_busy_q  <= 1'b1;
                rd_keep_q  <= 1'b1;
                rd_cnt_q   <= RW'(1);
            end else if (rd_busy_q) begin
                if (rd_cnt_q >= RD_STROBE) bus_read_q <= 1'b0;
                if (rd_cnt_q == RD_WAIT)   rd_busy_q  <= 1'b0;
                else                       rd_cnt_q   <= rd_cnt_q + 1'b1;
            end
            if (abort) rd_keep_q <= 1'b0;

            if (rd_busy_q && rd_keep_q && rd_cnt_q == RD_WAIT)
                tx_sh_q <= bus_readdata;
            else if (state_q == DATA && rnw_q && sclk_fall)
                tx_sh_q <= tx_sh_q << 1;

            // MSB goes out on DATA entry and again on the first fall, then one bit per fall
            if (turn_done && rnw_q)
                miso_q <= tx_sh_q[BusWidth-1];
            else if (state_q == DATA && rnw_q && sclk_fall)
                miso_q <= tx_sh_q[BusWidth-1];
            else if (state_q != DATA)
                miso_q <= 1'b0;

            if (state_q == DATA && !rnw_q && sclk_rise)
                rx_sh_q <= {rx_sh_q[BusWidth-3:0], mosi_s};

            if (data_done && !rnw_q) begin
                bus_writedata_q <= {rx_sh_q, mosi_s};
                bus_write_q     <= 1'b1;
                wr_cnt_q        <= SW'(1);
            end else if (state_q == WRITE_ISSUE) begin
                if (wr_done) bus_write_q <= 1'b0;
                else         wr_cnt_q    <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign miso_oe       = ~cs_n_s;
    assign spi_miso      = miso_q & ~cs_n_s;
    assign bus_address   = bus_address_q;
    assign bus_read      = bus_read_q;
    assign bus_write     = bus_write_q;
    assign bus_writedata = bus_writedata_q;
    assign frame_abort   = frame_abort_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: a bit-banged SPI master drives frames,
// a strobe monitor pops expected bus transactions from a scoreboard queue.
module tb_spi_reg_bridge;

    localparam int HALF      = 4;   // clklow cycles per sclk half period (sclk = clklow/8)
    localparam int READ_WAIT = 6;
    localparam int STROBE    = 2;
    localparam int FRAME     = 56;

    typedef struct packed {
        logic        rnw;
        logic [15:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clklow, resetN;
    logic        spi_sclk, spi_cs_n, spi_mosi;
    logic        spi_miso, miso_oe;
    logic [15:0] bus_address;
    logic        bus_read, bus_write, frame_abort;
    logic [31:0] bus_writedata, rd_value;

    int   checks = 0, errors = 0;
    int   aborts = 0, strobes = 0, pushed = 0;
    int   cyc = 0, rd_rise_cyc = 0;
    int   rlen = 0, wlen = 0;
    logic prev_r = 1'b0, prev_w = 1'b0;
    txn_t exp_q[$];

    spi_reg_bridge dut (
        .clklow        (clklow),
        .resetN        (resetN),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .miso_oe       (miso_oe),
        .bus_address   (bus_address),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_writedata (bus_writedata),
        .bus_readdata  (rd_value),
        .frame_abort   (frame_abort)
    );

    initial clklow = 1'b0;
    always #5 clklow = ~clklow;
    always @(posedge clklow) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_txn(input logic rnw, input logic [15:0] addr, input logic [31:0] data);
        exp_q.push_back({rnw, addr, data});
        pushed++;
    endtask

    // Strobe monitor: every rising strobe must match the head of the scoreboard
    always @(negedge clklow) begin
        if (!resetN) begin
            prev_r <= 1'b0;
            prev_w <= 1'b0;
            rlen   <= 0;
            wlen   <= 0;
        end else begin
            prev_r <= bus_read;
            prev_w <= bus_write;
            if (frame_abort) aborts <= aborts + 1;
            if (bus_read)    rlen   <= rlen + 1;
            if (bus_write)   wlen   <= wlen + 1;
            if ((bus_read && !prev_r) || (bus_write && !prev_w)) begin
                strobes <= strobes + 1;
                check("rw_exclusive", 64'(bus_read & bus_write), 64'd0);
                check("strobe_queued", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("strobe_dir", 64'(bus_read), 64'(exp_q[0].rnw));
                    check("bus_address", 64'(bus_address), 64'(exp_q[0].addr));
                    if (bus_write)
                        check("bus_writedata", 64'(bus_writedata), 64'(exp_q[0].data));
                    exp_q.delete(0);
                end
                if (bus_read) rd_rise_cyc <= cyc;
            end
            if (!bus_read && prev_r) begin
                check("read_strobe_len", 64'(rlen), 64'(STROBE));
                rlen <= 0;
            end
            if (!bus_write && prev_w) begin
                check("write_strobe_len", 64'(wlen), 64'(STROBE));
                wlen <= 0;
            end
        end
    end

    task automatic spi_frame(input logic rnw, input logic [15:0] addr, input logic [31:0] wdata,
                             input int nbits, input bit keep_cs, input int gap,
                             output logic [31:0] rword, output logic [7:0] extra);
        logic [55:0] fr;
        fr    = {rnw, addr[14:0], 8'h00, wdata};
        rword = '0;
        extra = '0;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clklow);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < FRAME) ? fr[55-i] : 1'b1;
            repeat (HALF) @(negedge clklow);
            if (i >= 24 && i < FRAME) rword = {rword[30:0], spi_miso};
            else if (i >= FRAME)      extra = {extra[6:0], spi_miso};
            if (i == 8) check("miso_oe_active", 64'(miso_oe), 64'd1);
            if (rnw && i == 24)
                check("rdata_ready_margin", 64'((cyc - rd_rise_cyc) > READ_WAIT), 64'd1);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clklow);
            spi_sclk = 1'b0;
        end
        if (!keep_cs) begin
            repeat (HALF) @(negedge clklow);
            spi_cs_n = 1'b1;
            repeat (gap) @(negedge clklow);
        end
    endtask

    initial begin
        logic [31:0] rw;
        logic [7:0]  ex;
        int          a0;
        resetN   = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        rd_value = 32'h0;
        repeat (5) @(negedge clklow);
        check("reset_outputs", 64'({spi_miso, miso_oe, bus_read, bus_write, frame_abort,
                                    bus_address, bus_writedata}), 64'd0);
        resetN = 1'b1;
        repeat (5) @(negedge clklow);

        // Plain write
        expect_txn(1'b0, 16'h1100, 32'h00FFF00F);
        spi_frame(1'b0, 16'h1100, 32'h00FFF00F, FRAME, 1'b0, 16, rw, ex);
        check("wr_address_hold", 64'(bus_address), 64'h1100);
        check("wr_data_hold", 64'(bus_writedata), 64'h00FFF00F);
        check("first_frame_strobes", 64'(strobes), 64'd1);
        check("miso_oe_idle", 64'(miso_oe), 64'd0);

        // Reads: ordinary, address zero, unaligned address
        rd_value = 32'h11111111;
        expect_txn(1'b1, 16'h0304, 32'h0);
        spi_frame(1'b1, 16'h0304, 32'h0, FRAME, 1'b0, 16, rw, ex);
        check("read_0304_miso", 64'(rw), 64'h11111111);
        check("miso_oe_after_read", 64'(miso_oe), 64'd0);

        rd_value = 32'hDEADBEEF;
        expect_txn(1'b1, 16'h0000, 32'h0);
        spi_frame(1'b1, 16'h0000, 32'h0, FRAME, 1'b0, 16, rw, ex);
        check("read_0000_miso", 64'(rw), 64'hDEADBEEF);

        rd_value = 32'hCAFEF00D;
        expect_txn(1'b1, 16'h1120, 32'h0);
        spi_frame(1'b1, 16'h1123, 32'h0, FRAME, 1'b0, 16, rw, ex);
        check("read_unaligned_miso", 64'(rw), 64'hCAFEF00D);

        // Write aborted after 30 bits, then a normal write
        a0 = aborts;
        spi_frame(1'b0, 16'h0040, 32'hFFFF0000, 30, 1'b0, 16, rw, ex);
        check("abort_pulses", 64'(aborts - a0), 64'd1);
        expect_txn(1'b0, 16'h0010, 32'h12345678);
        spi_frame(1'b0, 16'h0010, 32'h12345678, FRAME, 1'b0, 16, rw, ex);
        check("post_abort_wdata", 64'(bus_writedata), 64'h12345678);

        // Over-long read: extra bits must read back as zero
        rd_value = 32'hFFFFFFFF;
        expect_txn(1'b1, 16'h0008, 32'h0);
        spi_frame(1'b1, 16'h0008, 32'h0, FRAME + 4, 1'b0, 16, rw, ex);
        check("long_read_miso", 64'(rw), 64'hFFFFFFFF);
        check("long_read_extra", 64'(ex[3:0]), 64'd0);

        // Reset at bit 45 of a read; its bus_read has already happened
        rd_value = 32'h5A5A5A5A;
        expect_txn(1'b1, 16'h0200, 32'h0);
        spi_frame(1'b1, 16'h0200, 32'h0, 45, 1'b1, 0, rw, ex);
        resetN = 1'b0;
        #1;
        check("midframe_reset_outputs", 64'({spi_miso, miso_oe, bus_read, bus_write, frame_abort,
                                             bus_address, bus_writedata}), 64'd0);
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clklow);
        resetN = 1'b1;
        repeat (8) @(negedge clklow);
        rd_value = 32'h00A5A5A5;
        expect_txn(1'b1, 16'h1000, 32'h0);
        spi_frame(1'b1, 16'h1000, 32'h0, FRAME, 1'b0, 16, rw, ex);
        check("post_reset_read", 64'(rw), 64'h00A5A5A5);

        // Back-to-back frames, cs_n high for one sclk period in between
        expect_txn(1'b0, 16'h0020, 32'h0BADF00D);
        spi_frame(1'b0, 16'h0020, 32'h0BADF00D, FRAME, 1'b0, 2 * HALF, rw, ex);
        rd_value = 32'h76543210;
        expect_txn(1'b1, 16'h0024, 32'h0);
        spi_frame(1'b1, 16'h0024, 32'h0, FRAME, 1'b0, 16, rw, ex);
        check("b2b_read_miso", 64'(rw), 64'h76543210);
        check("b2b_wdata_hold", 64'(bus_writedata), 64'h0BADF00D);

        repeat (20) @(negedge clklow);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("total_strobes", 64'(strobes), 64'(pushed));
        check("total_aborts", 64'(aborts), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI-slave to register-bus initiator: an external SPI master (bench controller, second board) issues register reads and writes into the same address space the GPIO/ADC/capsense register decoder answers.
- It drives the address, read/write strobes and write data of the cpu-side register bus, and returns read data over MISO.
- It sits in the clklow domain beside the register decoder. SPI is oversampled; there is no SPI-clock domain.

Parameters:
- AddrWidth, 16, register bus byte-address width; cmd field carries bits [14:0], MSB forced 0.
- BusWidth, 32, data word width; fixed 32 in the frame format.
- SyncStages, 2, synchronizer depth on sclk, cs_n and mosi.
- DummyBits, 8, turnaround bits between address and data phases.
- ReadWait, 6, clklow cycles from bus_read assertion to readdata capture.
- StrobeLen, 2, clklow cycles each bus_read/bus_write stays high.

Ports:
- clklow, input, 1, system clock; must be at least 8x sclk.
- resetN, input, 1, asynchronous active-low reset.
- spi_sclk, input, 1, SPI clock, mode 0.
- spi_cs_n, input, 1, chip select, active low.
- spi_mosi, input, 1, serial data in, MSB first.
- spi_miso, output, 1, serial data out; 0 when miso_oe is low.
- miso_oe, output, 1, MISO output enable; high only while the synchronized cs_n is low.
- bus_address, output, AddrWidth, word-aligned byte address; [1:0] is always 0.
- bus_read, output, 1, read strobe.
- bus_write, output, 1, write strobe.
- bus_writedata, output, BusWidth, write data.
- bus_readdata, input, BusWidth, read data returned by the decoder.
- frame_abort, output, 1, one-cycle pulse when cs_n rises mid-frame.

Behaviour:
- Reset values: spi_miso, miso_oe, bus_read, bus_write, frame_abort = 0; bus_address, bus_writedata = 0; FSM = IDLE.
- Synchronization: all three SPI inputs pass through SyncStages FFs. Edges are detected on the synchronized sclk. MOSI is sampled on the sclk rising edge. MISO shifts on the falling edge; the MSB is presented when the DATA phase starts.
- Frame format, 16 + DummyBits + 32 = 56 bits:
  - bit 55 = R/nW (1 = read);
  - bits 54..40 = address [14:0];
  - then DummyBits turnaround bits, MOSI ignored;
  - then 32 data bits.
- FSM states:
  - IDLE → CMD on the cs_n falling edge; bit counter cleared.
  - CMD: shift 16 bits. On the 16th rising edge, latch bus_address = {addr[14:2],2'b00}. A read starts READ_ISSUE; either direction then enters TURN.
  - READ_ISSUE runs in parallel with TURN: bus_read high for StrobeLen cycles. ReadWait cycles after assertion, bus_readdata loads the MISO shift register.
  - TURN: count DummyBits rising edges, then → DATA.
  - DATA:
    - read: shift out the captured word MSB-first; MOSI is ignored.
    - write: shift in 32 bits.
    - On the 32nd rising edge, a write latches bus_writedata and goes → WRITE_ISSUE; a read goes → DONE.
  - WRITE_ISSUE: bus_write high for StrobeLen cycles, then → DONE.
  - DONE: ignore further sclk edges and hold MISO at 0 until cs_n rises, then → IDLE.
- Boundaries:
  - cs_n rises in CMD, TURN or DATA: → IDLE, pulse frame_abort, no bus_write. An in-flight bus_read finishes its StrobeLen and its data is discarded.
  - cs_n rises during WRITE_ISSUE: the strobe completes, with no abort pulse.
  - Read data not captured by the first DATA falling edge: impossible when clklow ≥ 8x sclk and DummyBits ≥ 2. The bench checks this constraint; the RTL does not.
  - More than 56 bits in a frame: the extras are ignored and MISO stays 0.
  - bus_read and bus_write are never high in the same cycle, and each frame produces at most one strobe.
  - Address 16'h0000 is legal.
  - Async reset mid-frame returns to IDLE immediately. Outputs return to reset values, no strobe is emitted, and the next cs_n falling edge starts a fresh frame.

Decomposition:
- Shared package (gpio_bus_pkg):
  - typedef spi_state_e {IDLE, CMD, TURN, DATA, WRITE_ISSUE, DONE};
  - constants CMD_BITS=16, DATA_BITS=32;
  - localparam FRAME_BITS derived from DummyBits.
- One sub-module: spi_edge_sync, holding the synchronizers plus sclk rise/fall and cs_n fall/rise pulse generation.
- The FSM, counters and shift registers stay in spi_reg_bridge.

Test Plan:
- Write frame R/nW=0, addr 0x1100, data 0x00FFF00F, sclk = clklow/8 → exactly one bus_write pulse of 2 cycles, bus_address=0x1100, bus_writedata=0x00FFF00F, no bus_read.
- Read frame addr 0x0304 with the bench returning 0x11111111 → one bus_read pulse, bus_address=0x0304, MISO shifts 0x11111111 MSB-first, miso_oe high only during cs_n low.
- Address 0x1123 (unaligned) read → bus_address=0x1120.
- cs_n raised after 30 bits of a write → frame_abort pulses once, no bus_write; the next full write frame works normally.
- resetN pulsed low at bit 45 of a read → all outputs 0 immediately, no further strobes; a following read of 0x1000 returns the bench value 0xA5A5A5.
- Two back-to-back frames with cs_n high for 1 sclk period → both execute, one strobe each, correct order.
